rv32_prefetch: RTL
==================

RV32_PREFETCH -- requirements
Module: rv32_prefetch

Interface
REQ-001 Parameter DEPTH, 4, number of queue slots; power of two, minimum 2.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port branch_taken_in  in  1  redirect/flush request from mem stage.
REQ-006 Port branch_pc_in  in  32  redirect target, sampled when branch_taken_in=1.
REQ-007 Port mem_req_out  out  1  instruction read request.
REQ-008 Port mem_addr_out  out  32  word address of request; bits[1:0]=0.
REQ-009 Port mem_gnt_in  in  1  request accepted this cycle.
REQ-010 Port mem_rvalid_in  in  1  read data valid; responses return in request order.
REQ-011 Port mem_rdata_in  in  32  read data.
REQ-012 Port valid_out  out  1  pc_out/instr_out hold an instruction for decode.
REQ-013 Port ready_in  in  1  decode accepts; transfer when valid_out&ready_in.
REQ-014 Ports pc_out, instr_out  out  32 each  address and word of head instruction.

Function
REQ-015 fetch_pc SHALL advance by 4 on each cycle with mem_req_out&mem_gnt_in; mem_addr_out=fetch_pc.
REQ-016 A slot SHALL be allocated (pc written, state PENDING) on grant; mem_req_out=1 only when allocated slots < DEPTH and branch_taken_in=0.
REQ-017 mem_rvalid_in with discard count 0 SHALL fill the oldest PENDING slot (state FILLED); slot states: FREE->PENDING->FILLED->FREE.
REQ-018 valid_out SHALL equal (head slot FILLED); a transfer frees the head slot and advances the head pointer modulo DEPTH.
REQ-019 Pointers (head, fill, alloc) SHALL wrap modulo DEPTH; full = DEPTH allocated slots, empty = 0; no request when full, valid_out=0 when empty.
REQ-020 Simultaneous grant, fill and transfer in one cycle SHALL all take effect; occupancy changes by (grant - transfer).
REQ-021 On branch_taken_in=1: all slots FREE, pointers zero, fetch_pc <= {branch_pc_in[31:2],2'b00}, discard <= PENDING count minus (rvalid this cycle ? 1 : 0); flush overrides any same-cycle transfer or grant.
REQ-022 While discard>0, each mem_rvalid_in SHALL be dropped and decrement discard; new requests are permitted during discard.
REQ-023 A request not yet granted MAY be withdrawn on flush; the memory side accepts withdrawal.
REQ-024 mem_rvalid_in with no PENDING slot and discard=0 SHALL be ignored and flagged by a simulation assertion.
REQ-025 Latency without bypass: rvalid in cycle N -> valid_out in cycle N+1; first mem_req_out in first cycle after reset release.

Reset
REQ-026 While reset_n=0: fetch_pc=RESET_PC, all slots FREE, pointers and discard 0, mem_req_out=0, valid_out=0, pc_out/instr_out=0.
REQ-027 Reset asserted mid-operation SHALL abandon outstanding responses; responses after reset release are treated per REQ-024.

Configuration
REQ-028 Macro RV32_PREFETCH_BYPASS_EN defined: when head slot PENDING and a non-discarded rvalid fills it, valid_out=1 same cycle with instr_out=mem_rdata_in; if ready_in, slot freed without reaching FILLED.
REQ-029 Macro undefined: no combinational path from mem_rdata_in/mem_rvalid_in to outputs; latency per REQ-025.

Structure
REQ-030 Package rv32_pkg SHALL hold XLEN=32, the slot-state enum (FREE/PENDING/FILLED) and the PC increment constant.
REQ-031 Slot storage and pointer logic SHALL be one sub-module rv32_prefetch_queue; flush, discard and fetch_pc logic remain in rv32_prefetch.

Verification
REQ-032 Reset release, memory 1-cycle latency, ready_in=1: addresses 0,4,8,...; valid_out first 2 cycles after first grant, pc_out=0.
REQ-033 ready_in=0, memory always grants: exactly DEPTH=4 grants (0..C), then mem_req_out=0; ready_in=1 drains in order.
REQ-034 Two requests pending, branch_taken_in with branch_pc_in=32'h103: next addr 32'h100; two stale responses dropped; first valid_out pc_out=32'h100.
REQ-035 Flush in same cycle as an rvalid and a transfer: discard=pending-1, transfer ignored, no stale instruction emitted.
REQ-036 Bypass defined, queue empty, rvalid with 32'h00000013, ready_in=1: valid_out and instr_out=32'h00000013 same cycle; undefined: one cycle later.
REQ-037 reset_n pulsed low with 3 pending: outputs reset immediately; restart at RESET_PC; stray rvalid after release triggers assertion only.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 instruction prefetch queue.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // Stale-response counter width; it has to cover requests left over from back-to-back flushes.
  localparam int DISCARD_W = 8;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_e;

endpackage

// File: rtl/rv32_prefetch_queue.sv
// Prefetch slot storage: per-slot state, pc and instruction word, plus head/fill/alloc pointers.
// Slots are allocated, filled and freed strictly in order; pointers wrap modulo DEPTH.
module rv32_prefetch_queue
  import rv32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic [CW-1:0]   pend_cnt_o,
  output slot_state_e     head_state_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [XLEN-1:0] head_instr_o
);

  slot_state_e     state_q   [DEPTH];
  slot_state_e     state_d   [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] alloc_q, alloc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d = state_q;
    head_d  = head_q;
    fill_d  = fill_q;
    alloc_d = alloc_q;
    count_d = count_q;
    pend_d  = pend_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = SLOT_FREE;
      head_d  = '0;
      fill_d  = '0;
      alloc_d = '0;
      count_d = '0;
      pend_d  = '0;
    end else begin
      if (fill_i) begin
        state_d[fill_q] = SLOT_FILLED;
        fill_d          = fill_q + PW'(1);
      end
      // Pop after fill so a bypassed head goes straight back to FREE.
      if (pop_i) begin
        state_d[head_q] = SLOT_FREE;
        head_d          = head_q + PW'(1);
      end
      if (alloc_i) begin
        state_d[alloc_q] = SLOT_PENDING;
        alloc_d          = alloc_q + PW'(1);
      end
      count_d = count_q + CW'(alloc_i) - CW'(pop_i);
      pend_d  = pend_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= SLOT_FREE;
      head_q  <= '0;
      fill_q  <= '0;
      alloc_q <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      alloc_q <= alloc_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // NOTE: payload arrays are not reset; a slot is only read once its state says it holds data.
  always_ff @(posedge clk) begin
    if (alloc_i && !flush_i) pc_mem[alloc_q] <= alloc_pc_i;
    if (fill_i && !flush_i)  instr_mem[fill_q] <= fill_data_i;
  end

  assign full_o       = (count_q == CW'(DEPTH));
  assign pend_cnt_o   = pend_q;
  assign head_state_o = state_q[head_q];
  assign head_pc_o    = pc_mem[head_q];
  assign head_instr_o = instr_mem[head_q];

endmodule

// File: rtl/rv32_prefetch.sv
// RV32 instruction prefetch: fetch PC, memory handshake, branch flush and stale-response discard.
// Define RV32_PREFETCH_BYPASS_EN to forward a response straight to decode when it fills the head slot.
module rv32_prefetch
  import rv32_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] branch_pc_in,
  output logic            mem_req_out,
  output logic [XLEN-1:0] mem_addr_out,
  input  logic            mem_gnt_in,
  input  logic            mem_rvalid_in,
  input  logic [XLEN-1:0] mem_rdata_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [DISCARD_W-1:0] discard_q, discard_d, outstanding;

  logic                 q_full;
  logic [CW-1:0]        pend_cnt;
  slot_state_e          head_state;
  logic [XLEN-1:0]      head_pc, head_instr;
  logic                 alloc_en, fill_en, pop_en, head_filled;

  // reset_n is folded in so no request leaks out while reset is held.
  assign mem_req_out  = reset_n && !q_full && !branch_taken_in;
  assign mem_addr_out = fetch_pc_q;
  assign alloc_en     = mem_req_out && mem_gnt_in;
  assign fill_en      = mem_rvalid_in && (discard_q == '0) && (pend_cnt != '0);
  assign head_filled  = (head_state == SLOT_FILLED);

`ifdef RV32_PREFETCH_BYPASS_EN
  logic bypass;
  // A pending head is always the oldest pending slot, so this response is its word.
  assign bypass    = fill_en && (head_state == SLOT_PENDING);
  assign valid_out = head_filled || bypass;
  assign instr_out = head_filled ? head_instr : (bypass ? mem_rdata_in : '0);
`else
  assign valid_out = head_filled;
  assign instr_out = head_filled ? head_instr : '0;
`endif

  assign pc_out = valid_out ? head_pc : '0;
  assign pop_en = valid_out && ready_in && !branch_taken_in;

  // Responses still owed at a flush: earlier stale ones plus everything pending now.
  assign outstanding = discard_q + DISCARD_W'(pend_cnt);

  always_comb begin
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    if (branch_taken_in) begin
      fetch_pc_d = {branch_pc_in[XLEN-1:2], 2'b00};
      discard_d  = outstanding - DISCARD_W'(mem_rvalid_in && (outstanding != '0));
    end else begin
      if (mem_rvalid_in && (discard_q != '0)) discard_d = discard_q - DISCARD_W'(1);
      if (alloc_en) fetch_pc_d = fetch_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  rv32_prefetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (branch_taken_in),
    .alloc_i      (alloc_en),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (fill_en),
    .fill_data_i  (mem_rdata_in),
    .pop_i        (pop_en),
    .full_o       (q_full),
    .pend_cnt_o   (pend_cnt),
    .head_state_o (head_state),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr)
  );

  // A response with nothing outstanding is dropped by fill_en; flag it in simulation.
  assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rvalid_in && (discard_q == '0) && (pend_cnt == '0)));

endmodule
